// File: rtl/bin_to_onehot_stream.sv
// Purpose: registered binary-index to one-hot decoder with valid/ready handshakes on both sides.
// Latency: one cycle from input handshake to onehot_o/valid_o when the output stage is free or draining.
// Backpressure: two-entry skid (main + skid); ready_o comes from the state register, never from ready_i.
module bin_to_onehot_stream #(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [BIN_WIDTH-1:0]    bin_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [ONEHOT_WIDTH-1:0] onehot_o,
    output logic                    err_o
);

    // Occupancy states: nothing held, main register only, main and skid both held.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Number of output lines expressed at index width + 1, so an index equal to
    // the width (the ONEHOT_WIDTH==1, bin_i==1 case) compares correctly.
    localparam logic [BIN_WIDTH:0] NUM_LINES = ONEHOT_WIDTH[BIN_WIDTH:0];

    // A stored entry is the already-decoded vector plus its out-of-range flag,
    // so the output side never needs to look at the binary index again.
    typedef struct packed {
        logic                    err;
        logic [ONEHOT_WIDTH-1:0] onehot;
    } entry_t;

    logic [1:0] state_q;
    logic [1:0] state_d;
    entry_t     main_q;
    entry_t     skid_q;
    entry_t     dec;
    logic       in_range;
    logic       in_hs;
    logic       out_hs;
    logic       main_ld_dec;
    logic       main_ld_skid;
    logic       main_clr;
    logic       skid_ld;

    // ready_o is a pure function of the registered state; it is forced low while
    // reset is applied so that a handshake attempted during reset is never seen
    // upstream as accepted.
    assign ready_o  = (state_q != ST_FULL) && !rst_i;
    assign valid_o  = (state_q != ST_EMPTY);
    assign onehot_o = main_q.onehot;
    assign err_o    = main_q.err;

    assign in_hs  = valid_i && ready_o;
    assign out_hs = valid_o && ready_i;

    // Decode the incoming index; an index past the last line gives an all-zero vector flagged as err.
    always_comb begin
        in_range   = ({1'b0, bin_i} < NUM_LINES);
        dec.err    = !in_range;
        dec.onehot = in_range ? (ONEHOT_WIDTH'(1) << bin_i) : '0;
    end

    // Next-state and register-load selection for the two-entry skid buffer.
    always_comb begin
        state_d      = state_q;
        main_ld_dec  = 1'b0;
        main_ld_skid = 1'b0;
        main_clr     = 1'b0;
        skid_ld      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    state_d     = ST_ONE;
                    main_ld_dec = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_hs && out_hs) begin
                    main_ld_dec = 1'b1;
                end else if (in_hs) begin
                    state_d = ST_FULL;
                    skid_ld = 1'b1;
                end else if (out_hs) begin
                    // Clear the vector on drain so idle selects sit at zero.
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                end
            end
            ST_FULL: begin
                // ready_o is low here, so only the output side can move.
                if (out_hs) begin
                    state_d      = ST_ONE;
                    main_ld_skid = 1'b1;
                end
            end
            default: begin
                state_d  = ST_EMPTY;
                main_clr = 1'b1;
            end
        endcase
    end

    // State and storage registers; reset discards both held entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (main_ld_dec) begin
                main_q <= dec;
            end else if (main_ld_skid) begin
                main_q <= skid_q;
            end else if (main_clr) begin
                main_q <= '0;
            end
            if (skid_ld) begin
                skid_q <= dec;
            end
        end
    end

`ifndef SYNTHESIS
    // A presented vector must be fully known.
    a_onehot_known: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_o |-> !$isunknown(onehot_o))
        else $error("bin_to_onehot_stream: onehot_o unknown while valid_o");

    // Stored vectors can never carry more than one hot line.
    a_main_pop: assert property (@(posedge clk_i) disable iff (rst_i)
        $countones(main_q.onehot) <= 1)
        else $fatal(1, "bin_to_onehot_stream: main entry has more than one bit set");

    a_skid_pop: assert property (@(posedge clk_i) disable iff (rst_i)
        $countones(skid_q.onehot) <= 1)
        else $fatal(1, "bin_to_onehot_stream: skid entry has more than one bit set");

    // A stalled output entry stays put until it is taken.
    a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> (valid_o && $stable(onehot_o) && $stable(err_o)))
        else $error("bin_to_onehot_stream: output changed while stalled");
`endif

endmodule

// File: tb/tb_bin_to_onehot_stream.sv
// Purpose: self-checking bench for bin_to_onehot_stream at widths 16, 12 and 1.
// Latency: checks one-cycle decode latency and full-throughput streaming.
// Backpressure: random valid/ready traffic against a queue reference model.
module tb_bin_to_onehot_stream;

    logic clk;
    logic rst;

    // Width-16 instance
    logic        v16, r16, rdy16, vo16, e16;
    logic [3:0]  b16;
    logic [15:0] oh16;

    // Width-12 instance
    logic        v12, r12, rdy12, vo12, e12;
    logic [3:0]  b12;
    logic [11:0] oh12;

    // Width-1 instance
    logic        v1, r1, rdy1, vo1, e1;
    logic [0:0]  b1;
    logic [0:0]  oh1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference queue for the width-16 instance: {err, onehot} per accepted index.
    logic [16:0] q16[$];
    logic        stall_prev;
    logic [15:0] prev_oh;
    logic        prev_err;

    bin_to_onehot_stream #(.ONEHOT_WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .valid_i(v16), .ready_o(rdy16), .bin_i(b16),
        .valid_o(vo16), .ready_i(r16), .onehot_o(oh16), .err_o(e16)
    );

    bin_to_onehot_stream #(.ONEHOT_WIDTH(12)) dut12 (
        .clk_i(clk), .rst_i(rst), .valid_i(v12), .ready_o(rdy12), .bin_i(b12),
        .valid_o(vo12), .ready_i(r12), .onehot_o(oh12), .err_o(e12)
    );

    bin_to_onehot_stream #(.ONEHOT_WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(rdy1), .bin_i(b1),
        .valid_o(vo1), .ready_i(r1), .onehot_o(oh1), .err_o(e1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode from the rules: index below width lights that line, else err with no lines.
    function automatic logic [16:0] ref_dec(input int w, input int b);
        logic [16:0] r;
        r = '0;
        if (b >= w) r[16] = 1'b1;
        else        r[b]  = 1'b1;
        return r;
    endfunction

    // One cycle on the width-16 instance; entered and left at a falling edge.
    task automatic cycle16(input logic v, input logic [3:0] b, input logic r);
        logic exp_rdy;
        logic in_hs;
        logic out_hs;
        int   occ;
        occ     = q16.size();
        exp_rdy = (occ < 2);
        check("ready16", rdy16, exp_rdy);
        check("valid16", vo16, occ > 0);
        if (occ > 0) begin
            check("onehot16", oh16, q16[0][15:0]);
            check("err16", e16, q16[0][16]);
        end
        if (stall_prev) begin
            check("hold_onehot16", oh16, prev_oh);
            check("hold_err16", e16, prev_err);
        end
        v16 = v;
        b16 = b;
        r16 = r;
        #1;
        // Changing ready_i/valid_i must not move ready_o within the cycle.
        check("ready16_no_comb", rdy16, exp_rdy);
        in_hs  = v && exp_rdy;
        out_hs = (occ > 0) && r;
        if (out_hs) void'(q16.pop_front());
        if (in_hs)  q16.push_back(ref_dec(16, int'(b)));
        stall_prev = (occ > 0) && !r;
        prev_oh    = oh16;
        prev_err   = e16;
        @(posedge clk);
        @(negedge clk);
    endtask

    int          bins12 [3] = '{11, 12, 15};
    logic [11:0] exp12  [3] = '{12'h800, 12'h000, 12'h000};
    logic        err12  [3] = '{1'b0, 1'b1, 1'b1};
    logic [0:0]  bins1  [2] = '{1'b0, 1'b1};
    logic [0:0]  exp1   [2] = '{1'b1, 1'b0};
    logic        err1   [2] = '{1'b0, 1'b1};

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        v16 = 0; b16 = '0; r16 = 1;
        v12 = 0; b12 = '0; r12 = 1;
        v1  = 0; b1  = '0; r1  = 1;
        stall_prev = 1'b0;
        prev_oh    = '0;
        prev_err   = 1'b0;

        // Reset: ready low while reset is held.
        repeat (3) @(negedge clk);
        check("rst_ready16", rdy16, 1'b0);
        check("rst_valid16", vo16, 1'b0);
        check("rst_onehot16", oh16, 16'h0000);
        check("rst_err16", e16, 1'b0);
        check("rst_ready12", rdy12, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_ready16", rdy16, 1'b1);
        check("post_rst_ready1", rdy1, 1'b1);
        @(negedge clk);

        // Basic decode: 0, 5, 15 back to back with ready_i high.
        cycle16(1, 4'd0, 1);
        check("basic_0", oh16, 16'h0001);
        cycle16(1, 4'd5, 1);
        check("basic_5", oh16, 16'h0020);
        cycle16(1, 4'd15, 1);
        check("basic_15", oh16, 16'h8000);
        check("basic_err", e16, 1'b0);
        cycle16(0, 4'd0, 1);
        check("basic_drained", vo16, 1'b0);

        // Back-pressure: 3 and 7 accepted, 9 waits until ready_o returns.
        cycle16(1, 4'd3, 0);
        check("bp_first", oh16, 16'h0008);
        cycle16(1, 4'd7, 0);
        check("bp_full_ready", rdy16, 1'b0);
        check("bp_hold_a", oh16, 16'h0008);
        cycle16(1, 4'd9, 0);
        check("bp_still_full", rdy16, 1'b0);
        check("bp_hold_b", oh16, 16'h0008);
        cycle16(1, 4'd9, 1);
        check("bp_second", oh16, 16'h0080);
        check("bp_ready_back", rdy16, 1'b1);
        cycle16(1, 4'd9, 1);
        check("bp_third", oh16, 16'h0200);
        cycle16(0, 4'd0, 1);
        check("bp_drained", vo16, 1'b0);

        // Reset mid-operation from FULL, with a handshake attempted during reset.
        cycle16(1, 4'd2, 0);
        cycle16(1, 4'd4, 0);
        check("mid_full", rdy16, 1'b0);
        rst = 1'b1;
        v16 = 1; b16 = 4'd6; r16 = 1;
        #1;
        check("mid_rst_ready", rdy16, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        v16 = 0;
        #1;
        check("mid_rst_valid", vo16, 1'b0);
        check("mid_rst_onehot", oh16, 16'h0000);
        check("mid_rst_err", e16, 1'b0);
        check("mid_rst_ready_after", rdy16, 1'b1);
        q16.delete();
        stall_prev = 1'b0;
        cycle16(0, 4'd0, 1);
        cycle16(0, 4'd0, 0);
        check("mid_rst_no_ghost", vo16, 1'b0);

        // Random valid/ready traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            cycle16($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        end
        // Drain whatever remains.
        for (int i = 0; i < 4; i++) cycle16(0, 4'd0, 1);
        check("rand_drained", vo16, 1'b0);

        // Non-power-of-two width: 11, 12, 15.
        for (int i = 0; i < 3; i++) begin
            v12 = 1'b1;
            b12 = 4'(bins12[i]);
            @(posedge clk);
            @(negedge clk);
            check("w12_valid", vo12, 1'b1);
            check("w12_onehot", oh12, exp12[i]);
            check("w12_err", e12, err12[i]);
            check("w12_ref", {e12, 4'b0, oh12}, ref_dec(12, bins12[i]));
        end
        v12 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w12_drained", vo12, 1'b0);

        // Degenerate width 1: index 0 then out-of-range index 1.
        for (int i = 0; i < 2; i++) begin
            v1 = 1'b1;
            b1 = bins1[i];
            @(posedge clk);
            @(negedge clk);
            check("w1_valid", vo1, 1'b1);
            check("w1_onehot", oh1, exp1[i]);
            check("w1_err", e1, err1[i]);
        end
        v1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w1_drained", vo1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
